clk_mask_ctrl: RTL

//  Clock-gating controller that drives the enable of a downstream clk_mask cell (mask_o=1 gates the clock off).

---
 rtl/clk_mask_ctrl_if.sv | 30 +++
 rtl/clk_mask_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/clk_mask_ctrl_if.sv
// Request/grant and gating-status bundle between
// UART-domain requesters and the clock-mask controller.
interface clk_mask_ctrl_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] req_i;
  logic               force_on_i;
  logic [NUM_REQ-1:0] ack_o;
  logic               mask_o;
  logic [1:0]         state_o;
  logic [15:0]        gate_events_o;

  modport master (
    output req_i,
    output force_on_i,
    input  ack_o,
    input  mask_o,
    input  state_o,
    input  gate_events_o
  );

  modport slave (
    input  req_i,
    input  force_on_i,
    output ack_o,
    output mask_o,
    output state_o,
    output gate_events_o
  );
endinterface

// File: rtl/clk_mask_ctrl.sv
// Clock-gating controller for a shared UART clock domain:
// ungates on request, grants after wake-up, re-gates on idle.
module clk_mask_ctrl #(
  parameter int NUM_REQ     = 2,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  clk_mask_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    GATED = 2'd0,
    WAKE  = 2'd1,
    RUN   = 2'd2,
    IDLE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_END =
    CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_END =
    CNT_W'(IDLE_CYCLES - 1);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;
  logic               ev_inc;
  logic               active;
  logic               mask_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [15:0]        ev_q;

  assign active = (|bus.req_i) | bus.force_on_i;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ev_inc   = 1'b0;
    case (state)
      GATED: begin
        if (active) begin
          state_nx = WAKE;
          cnt_nx   = '0;
        end
      end
      // wake-up always completes, even if requests drop
      WAKE: begin
        if (cnt == WAKE_END) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!active) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      IDLE: begin
        if (active) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else if (cnt == IDLE_END) begin
          state_nx = GATED;
          cnt_nx   = '0;
          ev_inc   = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = GATED;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= GATED;
      cnt    <= '0;
      mask_q <= 1'b1;
      ack_q  <= '0;
      ev_q   <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      mask_q <= (state_nx == GATED);
      ack_q  <= bus.req_i &
                {NUM_REQ{state_nx == RUN}};
      if (ev_inc && (ev_q != 16'hFFFF))
        ev_q <= ev_q + 16'd1;
    end
  end

  assign bus.mask_o        = mask_q;
  assign bus.ack_o         = ack_q;
  assign bus.state_o       = state;
  assign bus.gate_events_o = ev_q;

endmodule
